rr_pkt_arbiter_x_in: RTL and testbench

Round-robin packet arbiter that shares one router output port among `IO_SIZE` input requesters. It picks a winner starting from a rotating token and holds the grant until the winner's tail flit has been transferred. It then re-arbitrates with no bubble. It sits between the input-port request vectors and the output crossbar select of a DataNoC router.

---
 rtl/rr_x_in_pkg.sv | 14 +
 rtl/rr_pick_x_in.sv | 34 +++
 rtl/rr_pkt_arbiter_x_in.sv | 97 +++++++++
 tb/tb_rr_pkt_arbiter_x_in.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rr_x_in_pkg.sv
// rtl/rr_x_in_pkg.sv - shared state encoding and index helpers for the round-robin packet arbiter
package rr_x_in_pkg;

    typedef enum logic {
        RR_IDLE   = 1'b0,
        RR_LOCKED = 1'b1
    } rr_state_t;

    // Explicit wrap so indices never reach IO_SIZE even when IO_SIZE is not a power of two.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned size);
        return (idx == size - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick_x_in.sv
// rtl/rr_pick_x_in.sv - combinational cyclic priority picker starting at token
module rr_pick_x_in
    import rr_x_in_pkg::*;
#(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic [IO_SIZE-1:0] req,
    input  logic [IO_w-1:0]    token,
    output logic [IO_w-1:0]    sel_id,
    output logic [IO_SIZE-1:0] sel_onehot,
    output logic               sel_valid
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_id    = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < IO_SIZE; k++) begin
            idx = int'(token) + k;
            if (idx >= IO_SIZE) begin
                idx = idx - IO_SIZE;
            end
            if (!sel_valid && req[IO_w'(idx)]) begin
                sel_valid = 1'b1;
                sel_id    = IO_w'(idx);
            end
        end
    end

    assign sel_onehot = sel_valid ? ({{(IO_SIZE-1){1'b0}}, 1'b1} << sel_id) : '0;

endmodule

// File: rtl/rr_pkt_arbiter_x_in.sv
// rtl/rr_pkt_arbiter_x_in.sv - round-robin packet arbiter for one router output port
// Define RR_ARB_PKT_LOCK_EN to hold the grant until the tail flit; otherwise every flit re-arbitrates.
module rr_pkt_arbiter_x_in
    import rr_x_in_pkg::*;
#(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic               clk,
    input  logic               rst_p,
    input  logic [IO_SIZE-1:0] req,
    input  logic [IO_SIZE-1:0] tail,
    input  logic               out_ready,
    output logic [IO_SIZE-1:0] grant,
    output logic [IO_w-1:0]    grant_id,
    output logic               grant_valid,
    output logic               fire,
    output logic [IO_w-1:0]    token
);

    rr_state_t          state;
    logic               pkt_end;
    logic               release_now;
    logic [IO_SIZE-1:0] pick_req;
    logic [IO_w-1:0]    sel_id;
    logic [IO_SIZE-1:0] sel_onehot;
    logic               sel_valid;

    assign fire = grant_valid & req[grant_id] & out_ready;

`ifdef RR_ARB_PKT_LOCK_EN
    assign pkt_end = tail[grant_id];
`else
    logic unused_tail;
    assign unused_tail = ^tail;
    assign pkt_end     = 1'b1;
`endif

    assign release_now = (state == RR_LOCKED) & fire & pkt_end;

    // The releasing owner must not win its own re-arbitration in the same edge.
    assign pick_req = release_now ? (req & ~grant) : req;

    rr_pick_x_in #(
        .IO_SIZE (IO_SIZE),
        .IO_w    (IO_w)
    ) u_pick (
        .req        (pick_req),
        .token      (token),
        .sel_id     (sel_id),
        .sel_onehot (sel_onehot),
        .sel_valid  (sel_valid)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state       <= RR_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            token       <= '0;
        end else begin
            case (state)
                RR_IDLE: begin
                    if (sel_valid) begin
                        state       <= RR_LOCKED;
                        grant       <= sel_onehot;
                        grant_id    <= sel_id;
                        grant_valid <= 1'b1;
                        token       <= IO_w'(rr_wrap_inc(int'(sel_id), IO_SIZE));
                    end
                end
                RR_LOCKED: begin
                    if (release_now) begin
                        if (sel_valid) begin
                            grant    <= sel_onehot;
                            grant_id <= sel_id;
                            token    <= IO_w'(rr_wrap_inc(int'(sel_id), IO_SIZE));
                        end else begin
                            state       <= RR_IDLE;
                            grant       <= '0;
                            grant_id    <= '0;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= RR_IDLE;
                    grant       <= '0;
                    grant_id    <= '0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_pkt_arbiter_x_in.sv
// tb/tb_rr_pkt_arbiter_x_in.sv - directed and random checks of rr_pkt_arbiter_x_in against a reference model
module tb_rr_pkt_arbiter_x_in;

    localparam int N = 5;
    localparam int W = 3;
`ifdef RR_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_p;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         out_ready;
    logic [N-1:0] grant;
    logic [W-1:0] grant_id;
    logic         grant_valid;
    logic         fire;
    logic [W-1:0] token;

    int n_cmp = 0;
    int n_err = 0;

    int m_owner;
    int m_token;

    rr_pkt_arbiter_x_in #(.IO_SIZE(N), .IO_w(W)) dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .req         (req),
        .tail        (tail),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .fire        (fire),
        .token       (token)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int tok);
        for (int k = 0; k < N; k++) begin
            if (r[(tok + k) % N]) return (tok + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] t, input logic o);
        logic [N-1:0] exp_grant;
        logic         exp_fire;
        int           s;
        @(negedge clk);
        rst_p     = rst;
        req       = r;
        tail      = t;
        out_ready = o;
        #1;
        exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        exp_fire  = (m_owner >= 0) && r[m_owner] && o;
        check_eq("grant",       32'(grant),       32'(exp_grant));
        check_eq("grant_id",    32'(grant_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check_eq("token",       32'(token),       32'(m_token));
        check_eq("fire",        32'(fire),        32'(exp_fire));
        if (rst) begin
            m_owner = -1;
            m_token = 0;
        end else if (m_owner < 0) begin
            s = pick(r, m_token);
            if (s >= 0) begin
                m_owner = s;
                m_token = (s + 1) % N;
            end
        end else if (exp_fire && (!LOCK || t[m_owner])) begin
            s = pick(r & ~N'(1 << m_owner), m_token);
            m_owner = s;
            if (s >= 0) m_token = (s + 1) % N;
        end
    endtask

    initial begin
        rst_p     = 1'b1;
        req       = '0;
        tail      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        m_owner = -1;
        m_token = 0;

        // idle after reset
        step(1'b0, 5'b00000, 5'b00000, 1'b0);
        repeat (10) step(1'b0, 5'b00000, 5'b00000, 1'b1);

        // alternation between 2 and 4 with single-flit packets
        repeat (7) step(1'b0, 5'b10100, 5'b10100, 1'b1);
        step(1'b1, 5'b00000, 5'b00000, 1'b0);

        // requester 4, three flits with out_ready toggling
        step(1'b0, 5'b10000, 5'b00000, 1'b0);
        step(1'b0, 5'b10000, 5'b00000, 1'b1);
        step(1'b0, 5'b10000, 5'b00000, 1'b0);
        step(1'b0, 5'b10000, 5'b00000, 1'b1);
        step(1'b0, 5'b10000, 5'b00000, 1'b0);
        step(1'b0, 5'b10000, 5'b10000, 1'b1);
        repeat (2) step(1'b0, 5'b00000, 5'b00000, 1'b1);

        // id 1 locked, drops req mid-packet while 3 waits
        step(1'b1, 5'b00000, 5'b00000, 1'b0);
        step(1'b0, 5'b00010, 5'b00000, 1'b1);
        step(1'b0, 5'b01010, 5'b00000, 1'b1);
        repeat (2) step(1'b0, 5'b01000, 5'b00000, 1'b1);
        step(1'b0, 5'b01010, 5'b00010, 1'b1);
        repeat (3) step(1'b0, 5'b01000, 5'b01000, 1'b1);

        // reset while id 0 is mid-packet
        step(1'b1, 5'b00000, 5'b00000, 1'b0);
        repeat (3) step(1'b0, 5'b00001, 5'b00000, 1'b1);
        step(1'b1, 5'b00001, 5'b00000, 1'b1);
        repeat (3) step(1'b0, 5'b00001, 5'b00000, 1'b1);

        // all requesting, random tails
        step(1'b1, 5'b00000, 5'b00000, 1'b0);
        repeat (12) step(1'b0, 5'b11111, N'($urandom), 1'b1);

        // random traffic with rare resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0), N'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
